// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period computation,
// used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // Clock cycles per serial bit; integer division truncates.
   function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter. Pushes when full and pops when empty are
// dropped; pointers wrap naturally because the depth is a power of two.
module uart_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [7:0]                    push_data,
   input  logic                          pop,
   output logic [7:0]                    pop_data,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign do_push  = push && (count_q != FULL_COUNT);
   assign do_pop   = pop && (count_q != '0);
   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointer and occupancy tracking; a same-cycle push and pop cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO. The line output is registered
// from the next-state values so it changes on the same edge as the FSM.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50000000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] LAST_CNT   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              nonempty_q;
   logic              push;
   logic              pop;
   logic              bit_end;
   logic [7:0]        fifo_data;

   assign tx_ready = (fifo_count != FULL_COUNT);
   assign push     = tx_valid && tx_ready;
   assign bit_end  = (cnt_q == LAST_CNT);
   assign tx       = tx_q;
   assign busy     = (state_q != IDLE) || (fifo_count != '0);

   uart_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (tx_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .count     (fifo_count)
   );

   // Next-state, baud counting, FIFO pop and the line value for the next cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // nonempty_q holds off a fresh pop for one cycle after the first
            // byte lands, so the start bit begins two edges after acceptance.
            if (nonempty_q && (fifo_count != '0)) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               bit_d = '0;
               // Chain straight into the next frame when a byte is waiting.
               if (fifo_count != '0) begin
                  pop     = 1'b1;
                  shift_d = fifo_data;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   // State, counters, shift register and registered line output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         nonempty_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         nonempty_q <= (fifo_count != '0);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single frames, hand-written corner
// sequences and randomized traffic checked by a line-decoding reference model.
module tb_uart_tx;

   localparam int unsigned CF    = 1000000;
   localparam int unsigned BR    = 100000;
   localparam int          CPB   = 10;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   uart_tx #(
      .CLOCK_FREQ (CF),
      .BAUD_RATE  (BR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial forever #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         queued = 0;
   int         frames_started = 0;
   int         frames_done = 0;
   int         last_start_cyc = 0;
   logic [9:0] last_line = '0;
   bit         frame_active = 1'b0;
   bit         chk_en = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;   // line[i] = i-th bit period on tx
   } vec_t;
   vec_t vecs[7];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: decode the line sample by sample and compare each frame
   // with the next accepted byte.
   initial begin : monitor
      logic [99:0] s;
      logic [9:0]  line;
      logic [7:0]  b;
      logic [7:0]  e;
      bit          aborted;
      bit          shape_ok;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && tx === 1'b0) begin
            frame_active = 1'b1;
            frames_started++;
            queued--;
            last_start_cyc = cyc;
            start_q.push_back(cyc);
            s = '0;
            s[0] = tx;
            aborted = 1'b0;
            for (int i = 1; i < FRAME; i++) begin
               @(posedge clk);
               #1;
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               s[i] = tx;
            end
            if (aborted) begin
               frame_active = 1'b0;
            end else begin
               shape_ok = 1'b1;
               for (int k = 0; k < 10; k++) begin
                  line[k] = s[CPB * k + CPB / 2];
                  for (int j = 0; j < CPB; j++) begin
                     if (s[CPB * k + j] !== s[CPB * k]) shape_ok = 1'b0;
                  end
               end
               check("frame_shape", 32'(shape_ok), 1);
               check("frame_start_stop", 32'({line[9], line[0]}), 2);
               b = line[8:1];
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame_data: got %h expected no frame", b);
               end else begin
                  e = exp_q.pop_front();
                  if (b !== e) begin
                     errors++;
                     $display("FAIL frame_data: got %h expected %h", b, e);
                  end
               end
               last_line = line;
               frames_done++;
            end
         end else begin
            frame_active = 1'b0;
         end
      end
   end

   // Occupancy and status must follow the accepted-minus-started byte count.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (fifo_count !== 3'(queued) || tx_ready !== (queued != DEPTH) ||
             busy !== (queued != 0 || frame_active)) begin
            errors++;
            $display("FAIL invariant: count=%0d ready=%b busy=%b expected count=%0d ready=%b busy=%b",
                     fifo_count, tx_ready, busy, queued, queued != DEPTH,
                     queued != 0 || frame_active);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge with
   // tx_valid still high so calls can be chained on consecutive cycles.
   task automatic push_byte(input logic [7:0] b);
      bit done = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int i = 0; i < 1000 && !done; i++) begin
         if (tx_ready === 1'b1) done = 1'b1;
         @(posedge clk);
         if (done) begin
            exp_q.push_back(b);
            queued++;
         end
         @(negedge clk);
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: byte %h not accepted", b);
      end
   endtask

   task automatic wait_frames(input int target, input int budget);
      for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
      check("frames_done", 32'(frames_done), 32'(target));
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain_busy", 32'(busy), 0);
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int         n;
      int         s0;
      int         gap;
      bit         tx_low;
      logic [7:0] w;

      vecs[0] = '{8'h55, 10'b1010101010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h01, 10'b1000000010};
      vecs[4] = '{8'h80, 10'b1100000000};
      vecs[5] = '{8'h3C, 10'b1001111000};
      vecs[6] = '{8'hA5, 10'b1101001010};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(tx_ready), 1);
      check("rst_count", 32'(fifo_count), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (30) @(negedge clk);
      check("no_frame_after_reset", 32'(frames_started), 0);

      // Single frames: latency, line pattern, busy release, input stability.
      foreach (vecs[v]) begin
         n = frames_done;
         push_byte(vecs[v].data);
         tx_valid = 1'b0;
         tx_data  = ~vecs[v].data;
         check("lat_edge0_tx", 32'(tx), 1);
         @(negedge clk);
         check("lat_edge1_tx", 32'(tx), 1);
         @(negedge clk);
         check("lat_edge2_tx", 32'(tx), 0);
         for (int i = 0; i < 200 && frames_done == n; i++) @(negedge clk);
         check("frame_line", 32'(last_line), 32'(vecs[v].line));
         check("busy_last_stop", 32'(busy), 1);
         @(negedge clk);
         check("busy_end", 32'(busy), 0);
         check("idle_tx", 32'(tx), 1);
      end

      // Back-to-back pushes give contiguous frames.
      n  = frames_done;
      s0 = start_q.size();
      push_byte(8'hA3);
      check("b2b_count1", 32'(fifo_count), 1);
      push_byte(8'h0F);
      check("b2b_count2", 32'(fifo_count), 2);
      push_byte(8'hFF);
      check("b2b_count3", 32'(fifo_count), 2);
      tx_valid = 1'b0;
      wait_frames(n + 3, 500);
      if (start_q.size() >= s0 + 3) begin
         check("b2b_gap1", 32'(start_q[s0 + 1] - start_q[s0]), FRAME);
         check("b2b_gap2", 32'(start_q[s0 + 2] - start_q[s0 + 1]), FRAME);
      end else begin
         checks++;
         errors++;
         $display("FAIL b2b_starts: got %0d frames expected 3", start_q.size() - s0);
      end
      wait_idle(300);
      check("b2b_count_end", 32'(fifo_count), 0);

      // Full FIFO stalls the producer without losing the held byte.
      n = frames_done;
      for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
      tx_data = 8'h6E;
      check("full_ready", 32'(tx_ready), 0);
      check("full_count", 32'(fifo_count), DEPTH);
      push_byte(8'h6E);
      tx_valid = 1'b0;
      wait_frames(n + 6, 1000);
      wait_idle(300);

      // Push on the edge that ends STOP while two bytes wait.
      n = frames_done;
      push_byte(8'hC1);
      push_byte(8'hC2);
      push_byte(8'hC3);
      tx_valid = 1'b0;
      for (int i = 0; i < 300 && cyc != last_start_cyc + FRAME - 1; i++) @(negedge clk);
      w = 8'hC4;
      tx_data  = w;
      tx_valid = 1'b1;
      check("simul_ready", 32'(tx_ready), 1);
      @(posedge clk);
      exp_q.push_back(w);
      queued++;
      @(negedge clk);
      tx_valid = 1'b0;
      check("simul_count", 32'(fifo_count), 2);
      check("simul_contiguous", 32'(start_q[$]), 32'(last_start_cyc));
      check("simul_start_cyc", 32'(start_q[$] - start_q[start_q.size() - 2]), FRAME);
      wait_frames(n + 4, 600);
      wait_idle(300);

      // Reset during data bit 3 of 0x00 with two bytes queued.
      push_byte(8'h00);
      push_byte(8'h5A);
      push_byte(8'hA5);
      tx_valid = 1'b0;
      for (int i = 0; i < 300 && cyc != last_start_cyc + CPB * 4 + CPB / 2; i++) @(negedge clk);
      check("pre_reset_tx", 32'(tx), 0);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("midrst_tx", 32'(tx), 1);
      check("midrst_count", 32'(fifo_count), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_ready", 32'(tx_ready), 1);
      exp_q.delete();
      queued = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      n = frames_started;
      tx_low = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_low = 1'b1;
      end
      check("post_rst_line_idle", 32'(tx_low), 0);
      check("post_rst_no_frame", 32'(frames_started - n), 0);

      // Randomized traffic with bursts and idle gaps.
      for (int r = 0; r < 25; r++) begin
         gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 150)) : 0;
         if (gap > 0) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            repeat (gap) @(negedge clk);
         end
         push_byte(8'($urandom));
      end
      tx_valid = 1'b0;
      wait_idle(4000);
      check("random_all_sent", 32'(exp_q.size()), 0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in baud.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit buffer depth in bytes; power of two, at least 2.
REQ-004 clk  input  1  system clock; the block uses only this clock.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tx_data  input  8  byte to send; sampled when tx_valid and tx_ready are both high.
REQ-007 tx_valid  input  1  producer request to enqueue tx_data.
REQ-008 tx_ready  output  1  high when the FIFO can accept a byte; equals (fifo_count != FIFO_DEPTH).
REQ-009 tx  output  1  serial line, 8N1 format, idle high, registered output.
REQ-010 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued but not yet started.

Function
REQ-012 CLKS_PER_BIT SHALL equal CLOCK_FREQ/BAUD_RATE (integer division); every bit period on tx SHALL last exactly CLKS_PER_BIT cycles (5208 at defaults).
REQ-013 Frame format SHALL be: start bit 0, data bits D0..D7 LSB first, one stop bit 1; total length 10*CLKS_PER_BIT cycles.
REQ-014 Handshake: a byte SHALL be enqueued on each rising edge where tx_valid=1 and tx_ready=1; tx_valid while tx_ready=0 SHALL be ignored and leave no side effects.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1. When fifo_count>0, the FSM SHALL pop the head byte into a shift register and go to START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_index=0.
REQ-018 DATA: tx=shift[bit_index] for CLKS_PER_BIT cycles per bit; after bit 7 go to STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles. At the end, pop the next byte and go directly to START if fifo_count>0 (no idle gap), otherwise go to IDLE.
REQ-020 Latency: with the block idle and the FIFO empty, tx SHALL fall exactly 2 clk edges after the accepting edge.
REQ-021 Simultaneous push and pop in the same cycle SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-022 Full: fifo_count=FIFO_DEPTH forces tx_ready=0. Empty: no pop occurs. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Changes on tx_data or tx_valid after acceptance SHALL NOT affect a queued or in-flight byte.
REQ-024 busy SHALL fall on the same edge the FSM returns to IDLE with an empty FIFO.

Reset
REQ-025 On rst_n=0, asynchronously: tx=1, state=IDLE, baud counter=0, bit_index=0, FIFO pointers and fifo_count=0, busy=0, tx_ready=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (tx returns high) and discard all queued bytes.
REQ-027 After rst_n deasserts, no frame SHALL start until a new byte is accepted.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state_t enum (IDLE, START, DATA, STOP) and the CLKS_PER_BIT computation, so the existing receiver can reuse them.
REQ-029 The FIFO SHALL be a separate sub-module uart_fifo (parameter FIFO_DEPTH, 8-bit data, push/pop/count interface); the FSM, baud counter and shift register stay in uart_tx.

Verification (sim parameters: CLOCK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10)
REQ-030 Single byte: push 0x55 -> tx falls 2 cycles later; observed bits 0,1,0,1,0,1,0,1,0,1, each 10 cycles; frame 100 cycles; busy drops at the end.
REQ-031 Back-to-back: push 0xA3, 0x0F, 0xFF in consecutive cycles -> three contiguous frames, no idle cycles between them, bytes in push order, fifo_count sequence 1,2,2 then draining to 0.
REQ-032 Full: push 6 bytes with tx_valid held high -> tx_ready=0 once 4 are queued; the extra byte is not lost and is accepted when a slot frees; all bytes are transmitted in order.
REQ-033 Simultaneous push/pop: with the FIFO at count 2, push on the edge where STOP ends -> fifo_count stays 2 and order is preserved.
REQ-034 Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0x00 with 2 bytes queued -> tx=1 immediately, fifo_count=0, no further frames after release.
REQ-035 Data stability: change tx_data one cycle after acceptance of 0x3C -> the transmitted byte is still 0x3C.
